// File: rtl/axis_usr_pkg.sv
// rtl/axis_usr_pkg.sv - tuser field layout shared by the tagger and its bench
package axis_usr_pkg;

  localparam int TAG_LSB   = 0;
  localparam int TAG_W     = 16;
  localparam int SOF_BIT   = 16;
  localparam int STALL_LSB = 17;
  localparam int STALL_W   = 15;

endpackage

// File: rtl/axis_usr_skid.sv
// rtl/axis_usr_skid.sv - two-entry skid buffer (main + skid) with registered upstream ready
module axis_usr_skid #(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 i_enable,
  input  logic [PAYLOAD_W-1:0] i_s_tdata,
  input  logic                 i_s_tvalid,
  output logic                 o_s_tready,
  output logic [PAYLOAD_W-1:0] o_m_tdata,
  output logic                 o_m_tvalid,
  input  logic                 i_m_tready
);

  logic [PAYLOAD_W-1:0] r_m_data;
  logic                 r_m_valid;
  logic [PAYLOAD_W-1:0] r_skid_data;
  logic                 r_skid_valid;
  logic                 r_s_ready;

  logic w_accept;
  logic w_main_free;
  logic w_skid_next;

  assign w_accept    = i_s_tvalid && r_s_ready;
  assign w_main_free = !r_m_valid || i_m_tready;
  // Ready is computed from the next-cycle skid occupancy so it can be registered.
  assign w_skid_next = w_main_free ? 1'b0 : (r_skid_valid || w_accept);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_m_data     <= r_skid_data;
          r_m_valid    <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_m_data  <= i_s_tdata;
          r_m_valid <= 1'b1;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_data  <= i_s_tdata;
        r_skid_valid <= 1'b1;
      end
      r_s_ready <= i_enable && !w_skid_next;
    end
  end

  assign o_s_tready = r_s_ready;
  assign o_m_tdata  = r_m_data;
  assign o_m_tvalid = r_m_valid;

endmodule

// File: rtl/axis_usr_tagger.sv
// rtl/axis_usr_tagger.sv - AXIS pass-through that tags each beat with sample count and frame start
// Optional stall-cycle field in tuser[31:17] enabled by AXIS_USR_TAGGER_STALL_CNT_EN.
module axis_usr_tagger
  import axis_usr_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int AXIS_TUSER_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enable,
  input  logic [15:0]                 cfg_frame_len,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser
);

  localparam int PAYLOAD_W = AXIS_TDATA_WIDTH + AXIS_TUSER_WIDTH;

  logic [TAG_W-1:0] r_sample_cnt;
  logic [15:0]      r_pos;
  logic [15:0]      r_len;

  logic                        w_s_tready;
  logic                        w_accept;
  logic                        w_sof;
  logic [15:0]                 w_len;
  logic [16:0]                 w_pos_inc;
  logic [15:0]                 w_pos_next;
  logic [AXIS_TUSER_WIDTH-1:0] w_tuser;
  logic [PAYLOAD_W-1:0]        w_m_payload;

  assign w_accept = s_axis_tvalid && w_s_tready;
  assign w_sof    = (r_pos == 16'd0);

  // The frame length in force for the first beat is the one being latched with it.
  assign w_len      = w_sof ? cfg_frame_len : r_len;
  assign w_pos_inc  = {1'b0, r_pos} + 17'd1;
  assign w_pos_next = (w_pos_inc >= {1'b0, w_len}) ? 16'd0 : w_pos_inc[15:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sample_cnt <= '0;
      r_pos        <= '0;
      r_len        <= '0;
    end else if (!cfg_enable) begin
      r_sample_cnt <= '0;
      r_pos        <= '0;
    end else if (w_accept) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
      r_pos        <= w_pos_next;
      if (w_sof) begin
        r_len <= cfg_frame_len;
      end
    end
  end

`ifdef AXIS_USR_TAGGER_STALL_CNT_EN
  logic [STALL_W-1:0] r_stall_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if (s_axis_tvalid && !w_s_tready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    w_tuser = '0;
    w_tuser[TAG_LSB +: TAG_W] = r_sample_cnt;
    w_tuser[SOF_BIT]          = w_sof;
`ifdef AXIS_USR_TAGGER_STALL_CNT_EN
    for (int i = 0; i < STALL_W; i++) begin
      if (STALL_LSB + i < AXIS_TUSER_WIDTH) begin
        w_tuser[STALL_LSB + i] = r_stall_cnt[i];
      end
    end
`endif
  end

  axis_usr_skid #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_enable   (cfg_enable),
    .i_s_tdata  ({w_tuser, s_axis_tdata}),
    .i_s_tvalid (s_axis_tvalid),
    .o_s_tready (w_s_tready),
    .o_m_tdata  (w_m_payload),
    .o_m_tvalid (m_axis_tvalid),
    .i_m_tready (m_axis_tready)
  );

  assign s_axis_tready = w_s_tready;
  assign m_axis_tdata  = w_m_payload[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tuser  = w_m_payload[PAYLOAD_W-1:AXIS_TDATA_WIDTH];

endmodule
